// File: rtl/iram_loader.sv
// iram_loader: streams instruction words from a host source into IRAM at address 0 upward.
// Latency: a word handshaken at edge k is written at edge k+1; best rate one word per two cycles.
// Backpressure: o_in_ready is high only in ACCEPT; the source holds valid/data until it sees ready.
//
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_start, i_len        load request and word count (legal 1..DEPTH), sampled only in IDLE
//   i_abort               cancel an in-progress load
//   i_in_valid/i_in_data  source word handshake, o_in_ready is the loader side
//   o_mem_write_en/o_mem_addr/o_mem_datain  IRAM write port
//   o_cpu_hold, o_busy    high whenever the loader is not idle
//   o_done, o_aborted, o_err_len  one-cycle completion / cancel / illegal-length pulses
//   o_count               words written in the current or last load
module iram_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_write_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_datain,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_aborted,
  output logic              o_err_len,
  output logic [ADDR_W:0]   o_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_DONE   = 3'd3,
    S_ABORT  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_ONE_C = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_ONE_A = ADDR_W'(1);

  state_t              r_state;
  state_t              w_next;

  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_datain;
  logic                r_err_len;

  logic                w_len_ok;
  logic [ADDR_W:0]     w_count_inc;
  logic                w_last;
  logic                w_take;

  logic                w_in_ready;
  logic                w_write_en;
  logic                w_busy;
  logic                w_done;
  logic                w_aborted;

  assign w_len_ok    = (i_len != '0) && (i_len <= LP_DEPTH);
  assign w_count_inc = r_count + LP_ONE_C;
  // The word being written in WRITE is the final one of the load.
  assign w_last      = (w_count_inc == r_len);
  // Handshake only completes when no abort competes for the same cycle.
  assign w_take      = (r_state == S_ACCEPT) && !i_abort && i_in_valid;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_write_en = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_aborted  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && w_len_ok) begin
          w_next = S_ACCEPT;
        end
      end

      S_ACCEPT: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (i_abort) begin
          w_next = S_ABORT;
        end else if (i_in_valid) begin
          w_next = S_WRITE;
        end
      end

      S_WRITE: begin
        w_write_en = 1'b1;
        w_busy     = 1'b1;
        // The write lands at this edge regardless; abort only redirects
        // where the FSM goes afterwards.
        if (i_abort) begin
          w_next = S_ABORT;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_ACCEPT;
        end
      end

      S_DONE: begin
        w_done = 1'b1;
        w_busy = 1'b1;
        w_next = S_IDLE;
      end

      S_ABORT: begin
        w_aborted = 1'b1;
        w_busy    = 1'b1;
        w_next    = S_IDLE;
      end

      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length latch, write address, captured word, written count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_len     <= '0;
      r_count   <= '0;
      r_addr    <= '0;
      r_datain  <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_len   <= i_len;
              r_count <= '0;
              r_addr  <= '0;
            end else begin
              r_err_len <= 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          if (w_take) begin
            r_datain <= i_in_data;
          end
        end

        S_WRITE: begin
          r_count <= w_count_inc;
          // Address only advances when another word will follow, so it
          // never wraps past DEPTH-1 on a full-depth load.
          if (!i_abort && !w_last) begin
            r_addr <= r_addr + LP_ONE_A;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // The processor is held for the whole non-idle span, including the
  // DONE/ABORT pulse cycle; it is released once back in IDLE.
  assign o_in_ready     = w_in_ready;
  assign o_mem_write_en = w_write_en;
  assign o_mem_addr     = r_addr;
  assign o_mem_datain   = r_datain;
  assign o_cpu_hold     = w_busy;
  assign o_busy         = w_busy;
  assign o_done         = w_done;
  assign o_aborted      = w_aborted;
  assign o_err_len      = r_err_len;
  assign o_count        = r_count;

endmodule

// File: tb/tb_iram_loader.sv
// Bench for iram_loader: directed and random loads checked against an IRAM image and write log.
// Inputs driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// The source honours in_ready; writes are observed by a monitor acting as the IRAM.
module tb_iram_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] len;
  logic       abort;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready, mem_we, cpu_hold, busy, done, aborted, err_len;
  logic [7:0] mem_addr, mem_datain;
  logic [8:0] count;

  int errors = 0;
  int checks = 0;

  iram_loader #(.ADDR_W(8), .DATA_W(8), .DEPTH(256)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_start        (start),
    .i_len          (len),
    .i_abort        (abort),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .o_mem_write_en (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_datain   (mem_datain),
    .o_cpu_hold     (cpu_hold),
    .o_busy         (busy),
    .o_done         (done),
    .o_aborted      (aborted),
    .o_err_len      (err_len),
    .o_count        (count)
  );

  always #5 clk = ~clk;

  // IRAM and event log, observed at the rising edge
  logic [7:0] iram [256];
  logic [7:0] log_addr [4096];
  logic [7:0] log_data [4096];
  int         log_cyc  [4096];
  int wr_n = 0, done_n = 0, abort_n = 0, err_n = 0, cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (mem_we === 1'b1) begin
      iram[mem_addr] = mem_datain;
      if (wr_n < 4096) begin
        log_addr[wr_n] = mem_addr;
        log_data[wr_n] = mem_datain;
        log_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (done === 1'b1)    done_n  = done_n + 1;
    if (aborted === 1'b1) abort_n = abort_n + 1;
    if (err_len === 1'b1) err_n   = err_n + 1;
  end

  logic [7:0] words [256];
  logic [7:0] exp_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [8:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Source side: optional idle cycles, then present the word until accepted.
  task automatic send(input logic [7:0] d, input int stall);
    int guard;
    in_valid = 1'b0;
    repeat (stall) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int l);
    int guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_done_pulse"}, 32'(done), 32'd1);
    chk({tag, "_hold_in_done"}, 32'(cpu_hold), 32'd1);
    @(negedge clk);
    chk({tag, "_done_drop"}, 32'(done), 32'd0);
    chk({tag, "_hold_release"}, {30'd0, cpu_hold, busy}, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'(l));
  endtask

  // Writes since 'base' must be addr i <- words[i], optionally exactly 2 cycles apart.
  task automatic check_writes(input string tag, input int base, input int n, input bit spacing);
    int mism = 0;
    int gaps = 0;
    chk({tag, "_nwrites"}, 32'(wr_n - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (log_addr[base+i] !== 8'(i) || log_data[base+i] !== words[i]) mism++;
      if (spacing && i > 0 && (log_cyc[base+i] - log_cyc[base+i-1]) != 2) gaps++;
      exp_mem[i] = words[i];
    end
    chk({tag, "_write_seq"}, 32'(mism), 32'd0);
    if (spacing) chk({tag, "_spacing"}, 32'(gaps), 32'd0);
  endtask

  task automatic check_image(input string tag, input int n);
    int mism = 0;
    for (int i = 0; i < n; i++) if (iram[i] !== exp_mem[i]) mism++;
    chk({tag, "_iram_image"}, 32'(mism), 32'd0);
  endtask

  initial begin
    int base, d0, a0, e0, stall, l;
    logic [8:0] cnt_before;

    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < 256; i++) begin iram[i] = 8'h00; exp_mem[i] = 8'h00; end
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_flags", {25'd0, in_ready, mem_we, cpu_hold, busy, done, aborted, err_len}, 32'd0);
    chk("rst_addr_data", {16'd0, mem_addr, mem_datain}, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load, source always ready
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    base = wr_n; d0 = done_n;
    start_load(9'd4);
    chk("basic_hold_after_start", 32'(cpu_hold), 32'd1);
    for (int i = 0; i < 4; i++) send(words[i], 0);
    wait_done("basic", 4);
    check_writes("basic", base, 4, 1'b1);
    chk("basic_done_once", 32'(done_n - d0), 32'd1);

    // Source stalls between words
    words[0] = 8'hA5; words[1] = 8'h5A; words[2] = 8'hFF;
    base = wr_n;
    start_load(9'd3);
    begin
      int bad = 0;
      for (int w = 0; w < 3; w++) begin
        if (w > 0) begin
          @(negedge clk);
          for (int s = 0; s < 5; s++) begin
            if (in_ready !== 1'b1 || mem_we !== 1'b0) bad++;
            @(negedge clk);
          end
        end
        send(words[w], 0);
      end
      chk("stall_ready_held", 32'(bad), 32'd0);
    end
    wait_done("stall", 3);
    check_writes("stall", base, 3, 1'b0);

    // Illegal lengths
    cnt_before = count; base = wr_n; e0 = err_n;
    start_load(9'd0);
    chk("len0_err", 32'(err_len), 32'd1);
    chk("len0_idle", {29'd0, busy, cpu_hold, mem_we}, 32'd0);
    @(negedge clk);
    chk("len0_err_drop", 32'(err_len), 32'd0);
    start_load(9'd257);
    chk("len257_err", 32'(err_len), 32'd1);
    chk("len257_idle", {29'd0, busy, cpu_hold, mem_we}, 32'd0);
    @(negedge clk);
    chk("illegal_err_pulses", 32'(err_n - e0), 32'd2);
    chk("illegal_count_kept", 32'(count), 32'(cnt_before));
    chk("illegal_no_writes", 32'(wr_n - base), 32'd0);

    // Abort in ACCEPT after 3 words, with a competing valid word
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    base = wr_n; d0 = done_n; a0 = abort_n;
    start_load(9'd8);
    for (int i = 0; i < 3; i++) send(words[i], 0);
    @(negedge clk);
    chk("abtA_in_accept", 32'(in_ready), 32'd1);
    abort = 1'b1; in_valid = 1'b1; in_data = words[3];
    @(negedge clk);
    chk("abtA_pulse", 32'(aborted), 32'd1);
    abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abtA_release", {30'd0, busy, cpu_hold}, 32'd0);
    chk("abtA_count", 32'(count), 32'd3);
    check_writes("abtA", base, 3, 1'b0);
    chk("abtA_no_done", 32'(done_n - d0), 32'd0);
    chk("abtA_one_abort", 32'(abort_n - a0), 32'd1);

    // Abort during WRITE of word 5
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    base = wr_n; d0 = done_n; a0 = abort_n;
    start_load(9'd8);
    for (int i = 0; i < 5; i++) send(words[i], 0);
    abort = 1'b1;
    @(negedge clk);
    chk("abtW_pulse", 32'(aborted), 32'd1);
    abort = 1'b0;
    @(negedge clk);
    chk("abtW_release", {30'd0, busy, cpu_hold}, 32'd0);
    chk("abtW_count", 32'(count), 32'd5);
    check_writes("abtW", base, 5, 1'b0);
    chk("abtW_no_done", 32'(done_n - d0), 32'd0);
    chk("abtW_one_abort", 32'(abort_n - a0), 32'd1);
    check_image("abtW", 8);

    // Full depth, word equals its address
    for (int i = 0; i < 256; i++) words[i] = 8'(i);
    base = wr_n;
    start_load(9'd256);
    for (int i = 0; i < 256; i++) send(words[i], 0);
    wait_done("full", 256);
    check_writes("full", base, 256, 1'b1);
    chk("full_last_addr_data", {16'd0, log_addr[base+255], log_data[base+255]}, 32'h0000FFFF);
    check_image("full", 256);

    // Reset in the middle of a second full-depth load
    for (int i = 0; i < 10; i++) words[i] = 8'($urandom);
    base = wr_n; d0 = done_n; a0 = abort_n;
    start_load(9'd256);
    for (int i = 0; i < 10; i++) send(words[i], 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_flags", {25'd0, in_ready, mem_we, cpu_hold, busy, done, aborted, err_len}, 32'd0);
    chk("midrst_regs", {7'd0, count, mem_addr, mem_datain}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_pulses", 32'((done_n - d0) + (abort_n - a0)), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);
    check_writes("midrst", base, 10, 1'b1);
    check_image("midrst", 256);

    // start pulses during a load are ignored
    for (int i = 0; i < 4; i++) words[i] = 8'($urandom);
    base = wr_n; d0 = done_n;
    start_load(9'd4);
    send(words[0], 0);
    start = 1'b1; len = 9'd2;
    send(words[1], 0);
    send(words[2], 0);
    start = 1'b0;
    send(words[3], 0);
    wait_done("busystart", 4);
    check_writes("busystart", base, 4, 1'b0);
    chk("busystart_done_once", 32'(done_n - d0), 32'd1);

    // Random loads with random source stalls
    for (int t = 0; t < 6; t++) begin
      l = $urandom_range(1, 24);
      for (int i = 0; i < l; i++) words[i] = 8'($urandom);
      base = wr_n; d0 = done_n;
      start_load(9'(l));
      for (int i = 0; i < l; i++) begin
        stall = $urandom_range(0, 3);
        send(words[i], stall);
      end
      wait_done($sformatf("rnd%0d", t), l);
      check_writes($sformatf("rnd%0d", t), base, l, 1'b0);
      chk($sformatf("rnd%0d_done_once", t), 32'(done_n - d0), 32'd1);
    end
    check_image("rnd_final", 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
